// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it into the register file,
// serves two read ports and counts retired writes. Define WB_REGFILE_BYPASS_EN for write-first forwarding.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_ctl_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] write_reg_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              reg_write;
  logic              mem_to_reg;

  assign reg_write  = wb_ctl_in[1];
  assign mem_to_reg = wb_ctl_in[0];
  assign wb_data    = mem_to_reg ? read_data_in : alu_result_in;
  assign wb_we      = reg_write && (write_reg_in != '0);

  // Entry 0 is cleared on reset and never written, so it always reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      wb_count <= '0;
    end else if (wb_we) begin
      regs[write_reg_in] <= wb_data;
      wb_count           <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
    // Forwarding is suppressed under reset so reads reflect the cleared state.
    if (wb_we && !reset && (rs_addr == write_reg_in)) begin
      rs_data = wb_data;
    end
`endif
    if (rs_addr == '0) begin
      rs_data = '0;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we && !reset && (rt_addr == write_reg_in)) begin
      rt_data = wb_data;
    end
`endif
    if (rt_addr == '0) begin
      rt_data = '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor checks them.
module tb_wb_regfile;

  localparam int SIG_RS   = 0;
  localparam int SIG_RT   = 1;
  localparam int SIG_WBD  = 2;
  localparam int SIG_WE   = 3;
  localparam int SIG_CNT  = 4;
  localparam int SIG_CNT4 = 5;

  logic        clk;
  logic        reset;
  logic [1:0]  wb_ctl_in;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  write_reg_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] wb_count;

  logic [31:0] rs_data4;
  logic [31:0] rt_data4;
  logic [31:0] wb_data4;
  logic        wb_we4;
  logic [3:0]  wb_count4;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] actual;
  int          checks;
  int          errors;
  logic        done;

  wb_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb_ctl_in    (wb_ctl_in),
    .read_data_in (read_data_in),
    .alu_result_in(alu_result_in),
    .write_reg_in (write_reg_in),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_we        (wb_we),
    .wb_count     (wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .wb_ctl_in    (wb_ctl_in),
    .read_data_in (read_data_in),
    .alu_result_in(alu_result_in),
    .write_reg_in (write_reg_in),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data4),
    .rt_data      (rt_data4),
    .wb_data      (wb_data4),
    .wb_we        (wb_we4),
    .wb_count     (wb_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    done = 1'b0;
    #100000;
    if (!done) begin
      $display("FAIL watchdog: stimulus did not finish in time");
      $finish;
    end
  end

  task automatic push(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
    wb_ctl_in     = ctl;
    read_data_in  = rd;
    alu_result_in = alu;
    write_reg_in  = wr;
    rs_addr       = rs;
    rt_addr       = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: expectations queued after an edge are compared at the following falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.sig)
        SIG_RS:   actual = rs_data;
        SIG_RT:   actual = rt_data;
        SIG_WBD:  actual = wb_data;
        SIG_WE:   actual = {31'b0, wb_we};
        SIG_CNT:  actual = wb_count;
        default:  actual = {28'b0, wb_count4};
      endcase
      checks++;
      if (actual !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.name, actual, cur.exp);
      end
    end
  end

  logic [31:0] byp_exp;

  initial begin
    checks = 0;
    errors = 0;

    // Writes held off while reset is high.
    reset = 1'b1;
    drive(2'b10, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    #1;
    check_now("rst_now_rs", rs_data, 32'h0);
    check_now("rst_now_rt", rt_data, 32'h0);
    check_now("rst_now_cnt", wb_count, 32'h0);
    push("rst_rs", SIG_RS, 32'h0);
    push("rst_rt", SIG_RT, 32'h0);
    push("rst_cnt", SIG_CNT, 32'h0);
    repeat (3) step();
    push("rst_hold_rs", SIG_RS, 32'h0);
    push("rst_hold_cnt", SIG_CNT, 32'h0);
    step();
    reset = 1'b0;
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    push("rel_rs5", SIG_RS, 32'hDEADBEEF);
    push("rel_cnt", SIG_CNT, 32'd1);
    step();

    // Mux select.
    drive(2'b11, 32'h0000_1234, 32'h5555_AAAA, 5'd9, 5'd0, 5'd0);
    push("mux_ld_wbd", SIG_WBD, 32'h0000_1234);
    push("mux_ld_we", SIG_WE, 32'd1);
    step();
    drive(2'b10, 32'h0000_1234, 32'h5555_AAAA, 5'd9, 5'd9, 5'd0);
`ifdef WB_REGFILE_BYPASS_EN
    byp_exp = 32'h5555_AAAA;
`else
    byp_exp = 32'h0000_1234;
`endif
    push("mux_ld_r9", SIG_RS, byp_exp);
    push("mux_alu_wbd", SIG_WBD, 32'h5555_AAAA);
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    push("mux_alu_rs", SIG_RS, 32'h5555_AAAA);
    push("mux_alu_rt", SIG_RT, 32'h5555_AAAA);
    push("mux_cnt", SIG_CNT, 32'd3);
    step();

    // Register 0 protection.
    drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd9);
    push("r0_we", SIG_WE, 32'd0);
    push("r0_rs_byp", SIG_RS, 32'h0);
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    push("r0_rs", SIG_RS, 32'h0);
    push("r0_cnt", SIG_CNT, 32'd3);
    step();

    // Same-cycle read of the write target.
    drive(2'b10, 32'h0, 32'h11, 5'd7, 5'd0, 5'd0);
    step();
    drive(2'b10, 32'h0, 32'hAB, 5'd7, 5'd7, 5'd7);
`ifdef WB_REGFILE_BYPASS_EN
    byp_exp = 32'hAB;
`else
    byp_exp = 32'h11;
`endif
    push("same_rs_pre", SIG_RS, byp_exp);
    push("same_rt_pre", SIG_RT, byp_exp);
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    push("same_rs_post", SIG_RS, 32'hAB);
    push("same_rt_post", SIG_RT, 32'hAB);
    push("same_cnt", SIG_CNT, 32'd5);
    step();

    // Ten writes with five bubbles aimed at reg 10.
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, 32'h0, 32'd100 + 32'(i), 5'd10 + 5'(i), 5'd0, 5'd0);
      step();
      if (i % 2 == 1) begin
        drive(2'b00, 32'hBAD, 32'hBAD, 5'd10, 5'd10, 5'd0);
        push("bub_we", SIG_WE, 32'd0);
        push("bub_r10", SIG_RS, 32'd100);
        step();
      end
    end
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd10, 5'd19);
    push("bub_r10_end", SIG_RS, 32'd100);
    push("bub_r19", SIG_RT, 32'd109);
    push("bub_cnt", SIG_CNT, 32'd15);
    step();

    // Asynchronous reset between edges, with a write pending on the next edge.
    drive(2'b10, 32'h0, 32'h77, 5'd3, 5'd0, 5'd0);
    step();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    push("async_pre_r3", SIG_RS, 32'h77);
    step();
    reset = 1'b1;
    drive(2'b10, 32'h0, 32'h44, 5'd4, 5'd3, 5'd10);
    #1;
    check_now("async_now_r3", rs_data, 32'h0);
    check_now("async_now_cnt", wb_count, 32'h0);
    push("async_r3", SIG_RS, 32'h0);
    push("async_r10", SIG_RT, 32'h0);
    push("async_cnt", SIG_CNT, 32'h0);
    step();
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    push("async_r4_dropped", SIG_RS, 32'h0);
    push("async_cnt_after", SIG_CNT, 32'h0);
    step();

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      drive(2'b11, 32'h1000 + 32'(i), 32'h0, 5'd1, 5'd0, 5'd0);
      step();
    end
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0);
    push("wrap_cnt32", SIG_CNT, 32'd17);
    push("wrap_cnt4", SIG_CNT4, 32'd1);
    push("wrap_r1", SIG_RS, 32'h1010);
    step();

    step();
    step();
    done = 1'b1;
    if (errors != 0 || checks == 0) begin
      $display("FAIL summary: %0d errors in %0d checks", errors, checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
